mmio_bus_responder: RTL and testbench
=====================================

// Module: mmio_bus_responder
// PURPOSE
//  Responder side of the pipeline core's load/store port: services word loads/stores for a data RAM
//  plus a memory-mapped I/O page (LEDs, debounced switches, free-running timer with compare flag).
//  Sits on the MEM stage; uses a valid/ready request and a one-cycle response pulse so RAM wait
//  states and I/O side effects are explicit and cycle-exact.
// PARAMETERS
//  RAM_WORDS        64          data RAM depth in 32-bit words (power of 2, 4..1024)
//  RAM_WAIT         1           extra wait cycles for RAM reads (0..7)
//  IO_BASE          32'hFF00    base byte address of the I/O page
//  DEBOUNCE_CYCLES  16          cycles a synchronised switch value must be stable before it is taken
// PORTS
//  clk        in   1   clock, all logic on rising edge
//  rst_n      in   1   synchronous active-low reset
//  req_valid  in   1   request present
//  req_ready  out  1   responder can accept (high only in IDLE)
//  req_write  in   1   1 = store, 0 = load
//  req_addr   in   32  byte address; bits [1:0] ignored (word access only)
//  req_wdata  in   32  store data
//  rsp_valid  out  1   one-cycle pulse: load data / store ack
//  rsp_rdata  out  32  load data (0 for stores and errors)
//  rsp_err    out  1   qualified by rsp_valid: address unmapped
//  switches   in   8   raw asynchronous board switches
//  leds       out  8   LED register
//  timer_irq  out  1   level; equals timer match flag
// BEHAVIOUR
//  Reset (rst_n low at posedge): state IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0,
//   leds=0, timer count=0, compare=32'hFFFF_FFFF, flag=0, switch regs=0. RAM contents not cleared.
//   Reset mid-transaction abandons it; no response is issued.
//  Map: RAM at [0, RAM_WORDS*4). IO_BASE+0x0 LED (RW, bits[7:0]); +0x4 SW (RO, debounced, zero-ext);
//   +0x8 TCOUNT (RW); +0xC TCMP (RW); +0x10 STATUS (bit0 flag, write-1-to-clear). Else unmapped.
//  FSM: IDLE -> accept when req_valid&req_ready.
//   Store or I/O load: -> RESP next cycle. RAM load: -> WAIT for RAM_WAIT cycles (skip if 0) -> RESP.
//   RESP: rsp_valid=1 one cycle, req_ready=0, -> IDLE. No response back-pressure.
//   Load latency = 1 cycle (I/O, unmapped) or 1+RAM_WAIT (RAM) from accept edge to rsp_valid.
//  Stores commit at the accept edge; ack pulse follows in RESP. Unmapped: store dropped, load rdata=0,
//   rsp_err=1. Writes to SW ignored (no error). Read of a word stored earlier returns the new value.
//  Load data captured at accept edge for I/O (TCOUNT value = count at that edge), at end of WAIT for RAM.
//  Timer: count increments every cycle, wraps 32'hFFFF_FFFF -> 0. CPU write to TCOUNT wins over
//   increment that cycle. Flag sets when count==TCMP (pre-increment value); sticky until cleared.
//   Same-cycle match and W1C clear: set wins.
//  Switches: 2-flop synchroniser, then stability counter; when synchronised value unchanged for
//   DEBOUNCE_CYCLES consecutive cycles, SW register loads it. Any change restarts the counter.
//  req_valid while req_ready=0 is ignored (requester must hold until accepted).
// TESTING
//  1 reset, store 0x1234_5678 to 0x8, load 0x8 -> ack 1 cycle after accept; load rsp 1+RAM_WAIT later =0x1234_5678, err=0
//  2 store 0xA5 to IO_BASE -> leds=8'hA5 on the cycle after accept; load IO_BASE -> rdata=0xA5
//  3 switches 0x3C with 4-cycle glitches then stable -> SW reads 0x3C only after 2+DEBOUNCE_CYCLES stable cycles
//  4 TCMP=20, TCOUNT=0 -> timer_irq rises when count passes 20; W1C STATUS=1 -> irq low; clear on match cycle -> irq stays 1
//  5 load 0x0001_0000 (unmapped) -> rsp_valid with rsp_err=1, rdata=0; store there -> err=1, RAM unchanged
//  6 assert rst_n=0 during RAM WAIT -> no rsp_valid, req_ready=1 and leds=0 the cycle after reset releases

Source files
------------

// File: rtl/mmio_bus_responder.sv
// Load/store responder for the MEM stage: word-addressed data RAM plus an I/O page
// (LEDs, debounced switches, free-running timer with sticky compare flag).
module mmio_bus_responder #(
  parameter int unsigned RAM_WORDS       = 64,
  parameter int unsigned RAM_WAIT        = 1,
  parameter logic [31:0] IO_BASE         = 32'hFF00,
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  input  logic [7:0]  switches,
  output logic [7:0]  leds,
  output logic        timer_irq
);

  localparam int          AW        = $clog2(RAM_WORDS);
  localparam int          DW        = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [31:0] RAM_BYTES = 32'(RAM_WORDS * 4);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t          state, state_nx;
  logic [2:0]      wait_cnt;
  logic [AW-1:0]   ram_idx_q;
  logic [31:0]     ram [RAM_WORDS];

  logic [31:0]     tcount, tcmp;
  logic            flag;
  logic [7:0]      sync1, sync2, sw_last, sw_reg;
  logic [DW-1:0]   db_cnt;

  // Byte-lane bits are masked off here so every access is a whole word.
  logic [31:0]     wa;
  logic [AW-1:0]   ram_idx;
  logic            accept, wr;
  logic            hit_ram, hit_led, hit_sw, hit_tcnt, hit_tcmp, hit_stat, unmapped;
  logic [31:0]     io_rdata;

  assign wa       = req_addr & 32'hFFFF_FFFC;
  assign ram_idx  = wa[AW+1:2];
  assign req_ready = (state == S_IDLE);
  assign rsp_valid = (state == S_RESP);
  assign accept   = req_valid && req_ready;
  assign wr       = accept && req_write;

  assign hit_ram  = (wa < RAM_BYTES);
  assign hit_led  = (wa == IO_BASE);
  assign hit_sw   = (wa == IO_BASE + 32'h4);
  assign hit_tcnt = (wa == IO_BASE + 32'h8);
  assign hit_tcmp = (wa == IO_BASE + 32'hC);
  assign hit_stat = (wa == IO_BASE + 32'h10);
  assign unmapped = !(hit_ram || hit_led || hit_sw || hit_tcnt || hit_tcmp || hit_stat);

  assign timer_irq = flag;

  always_comb begin
    io_rdata = 32'h0;
    if (hit_led)  io_rdata = {24'h0, leds};
    if (hit_sw)   io_rdata = {24'h0, sw_reg};
    if (hit_tcnt) io_rdata = tcount;
    if (hit_tcmp) io_rdata = tcmp;
    if (hit_stat) io_rdata = {31'h0, flag};
  end

  // FSM
  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: if (accept)
                state_nx = (!req_write && hit_ram && RAM_WAIT != 0) ? S_WAIT : S_RESP;
      S_WAIT: if (wait_cnt == 3'd0) state_nx = S_RESP;
      S_RESP: state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // Response capture: I/O and errors at the accept edge, RAM at the end of WAIT.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rsp_rdata <= 32'h0;
      rsp_err   <= 1'b0;
      wait_cnt  <= 3'd0;
      ram_idx_q <= '0;
    end else begin
      if (accept) begin
        rsp_err   <= unmapped;
        ram_idx_q <= ram_idx;
        wait_cnt  <= 3'(RAM_WAIT - 1);
        if (req_write || unmapped) rsp_rdata <= 32'h0;
        else if (hit_ram)          rsp_rdata <= ram[ram_idx];
        else                       rsp_rdata <= io_rdata;
      end
      if (state == S_WAIT) begin
        if (wait_cnt == 3'd0) rsp_rdata <= ram[ram_idx_q];
        else                  wait_cnt  <= wait_cnt - 3'd1;
      end
    end
  end

  // RAM has no reset; writes are blocked while reset is asserted.
  always_ff @(posedge clk) begin
    if (rst_n && wr && hit_ram) ram[ram_idx] <= req_wdata;
  end

  // LEDs and timer
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      leds   <= 8'h0;
      tcount <= 32'h0;
      tcmp   <= 32'hFFFF_FFFF;
      flag   <= 1'b0;
    end else begin
      tcount <= tcount + 32'h1;
      if (wr && hit_tcnt) tcount <= req_wdata;
      if (wr && hit_tcmp) tcmp   <= req_wdata;
      if (wr && hit_led)  leds   <= req_wdata[7:0];
      if (wr && hit_stat && req_wdata[0]) flag <= 1'b0;
      // a match in the same cycle as a clear keeps the flag set
      if (tcount == tcmp) flag <= 1'b1;
    end
  end

  // Switch synchroniser and debounce
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1   <= 8'h0;
      sync2   <= 8'h0;
      sw_last <= 8'h0;
      sw_reg  <= 8'h0;
      db_cnt  <= '0;
    end else begin
      sync1   <= switches;
      sync2   <= sync1;
      sw_last <= sync2;
      if (sync2 != sw_last)                      db_cnt <= '0;
      else if (db_cnt != DW'(DEBOUNCE_CYCLES-1)) db_cnt <= db_cnt + 1'b1;
      else                                       sw_reg <= sw_last;
    end
  end

endmodule

// File: tb/tb_mmio_bus_responder.sv
// Randomised bench for mmio_bus_responder against a transaction-level memory-map model.
module tb_mmio_bus_responder;
  localparam int unsigned RAM_WORDS = 64;
  localparam int unsigned RAM_WAIT  = 1;
  localparam logic [31:0] IO_BASE   = 32'hFF00;
  localparam int unsigned DEB       = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0, req_write = 1'b0;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic        req_ready, rsp_valid, rsp_err, timer_irq;
  logic [31:0] rsp_rdata;
  logic [7:0]  switches = 8'h0, leds;

  mmio_bus_responder #(.RAM_WORDS(RAM_WORDS), .RAM_WAIT(RAM_WAIT), .IO_BASE(IO_BASE),
                       .DEBOUNCE_CYCLES(DEB)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .switches(switches), .leds(leds), .timer_irq(timer_irq));

  always #5 clk = ~clk;

  int edge_no = 0;
  always @(posedge clk) edge_no <= edge_no + 1;

  int n_tests = 0, n_fail = 0;

  // model state
  logic [31:0] mem [RAM_WORDS];
  logic [7:0]  leds_m = 8'h0, sw_m = 8'h0;
  logic [31:0] tcmp_m = 32'hFFFF_FFFF, tc_v = 32'h0;
  int          tc_w = 0;   // edge at which the counter register held tc_v
  logic        flag_m = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic bit is_ram(input logic [31:0] a);
    return (a & 32'hFFFF_FFFC) < RAM_WORDS * 4;
  endfunction

  // {err, data} a load to addr accepted at edge acc should return
  function automatic logic [32:0] exp_rd(input logic [31:0] addr, input int acc);
    logic [31:0] a;
    a = addr & 32'hFFFF_FFFC;
    if (is_ram(a))                 return {1'b0, mem[a / 4]};
    if (a == IO_BASE)              return {1'b0, 24'h0, leds_m};
    if (a == IO_BASE + 32'h4)      return {1'b0, 24'h0, sw_m};
    if (a == IO_BASE + 32'h8)      return {1'b0, tc_v + 32'(acc - 1 - tc_w)};
    if (a == IO_BASE + 32'hC)      return {1'b0, tcmp_m};
    if (a == IO_BASE + 32'h10)     return {1'b0, 31'h0, flag_m};
    return {1'b1, 32'h0};
  endfunction

  task automatic model_wr(input logic [31:0] addr, input logic [31:0] wd, input int acc);
    logic [31:0] a;
    a = addr & 32'hFFFF_FFFC;
    if (is_ram(a))                  mem[a / 4] = wd;
    else if (a == IO_BASE)          leds_m = wd[7:0];
    else if (a == IO_BASE + 32'h8)  begin tc_v = wd; tc_w = acc; end
    else if (a == IO_BASE + 32'hC)  tcmp_m = wd;
    else if (a == IO_BASE + 32'h10) begin if (wd[0]) flag_m = 1'b0; end
  endtask

  task automatic txn(input logic w, input logic [31:0] addr, input logic [31:0] wd);
    logic [32:0] e;
    int acc, lat_exp;
    bit got;
    @(negedge clk);
    check("req_ready_idle", req_ready, 1);
    req_valid = 1'b1; req_write = w; req_addr = addr; req_wdata = wd;
    @(posedge clk); #1;
    acc = edge_no;
    req_valid = 1'b0;
    e = exp_rd(addr, acc);
    if (w) begin
      e[31:0] = 32'h0;
      model_wr(addr, wd, acc);
    end
    lat_exp = (!w && is_ram(addr)) ? 1 + RAM_WAIT : 1;
    check("leds", {24'h0, leds}, {24'h0, leds_m});
    got = 0;
    for (int i = 0; i < 16; i++) begin
      if (rsp_valid) begin got = 1; break; end
      @(posedge clk); #1;
    end
    check("rsp_seen", got, 1);
    if (got) begin
      check("latency", edge_no + 1 - acc, lat_exp);
      check("rdata", rsp_rdata, e[31:0]);
      check("err", rsp_err, e[32]);
      check("ready_in_resp", req_ready, 0);
      @(posedge clk); #1;
      check("rsp_pulse_end", rsp_valid, 0);
      check("ready_after", req_ready, 1);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; req_valid = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("rsp_valid_in_reset", rsp_valid, 0);
    end
    rst_n = 1'b1;
    leds_m = 8'h0; sw_m = 8'h0; tcmp_m = 32'hFFFF_FFFF; flag_m = 1'b0;
    tc_v = 32'h0; tc_w = edge_no;
  endtask

  logic [31:0] unm [5];
  int s, w2;

  initial begin
    unm[0] = 32'h0000_0100; unm[1] = IO_BASE + 32'h14; unm[2] = IO_BASE - 32'h4;
    unm[3] = 32'h0001_0000; unm[4] = 32'h8000_0040;

    // reset state
    do_reset();
    @(posedge clk); #1;
    check("rst_ready", req_ready, 1);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rdata", rsp_rdata, 0);
    check("rst_err", rsp_err, 0);
    check("rst_leds", {24'h0, leds}, 0);
    check("rst_irq", timer_irq, 0);

    // store then load a RAM word
    txn(1, 32'h8, 32'h1234_5678);
    txn(0, 32'h8, 0);
    check("ram_word2", mem[2], 32'h1234_5678);

    // fill RAM so every later load has known data
    for (int i = 0; i < RAM_WORDS; i++) txn(1, 32'(i * 4) | 32'($urandom_range(0, 3)), $urandom);
    txn(0, 32'h8, 0);

    // LED register
    txn(1, IO_BASE, 32'hFFFF_FFA5);
    check("leds_a5", {24'h0, leds}, 32'hA5);
    txn(0, IO_BASE, 0);

    // switch debounce with short glitches
    for (int g = 0; g < 3; g++) begin
      @(negedge clk); switches = 8'h3C;
      repeat (3) @(negedge clk);
      switches = 8'h3C ^ 8'($urandom_range(1, 255));
      repeat (4) @(negedge clk);
    end
    switches = 8'h3C;
    s = edge_no;
    while (edge_no < s + DEB - 3) begin @(posedge clk); #1; end
    txn(0, IO_BASE + 32'h4, 0);       // still the old value
    repeat (8) @(posedge clk);
    sw_m = 8'h3C;
    txn(0, IO_BASE + 32'h4, 0);

    // unmapped load/store; store must not alias into RAM
    txn(0, 32'h0001_0000, 0);
    txn(1, 32'h0001_0000, 32'hDEAD_BEEF);
    txn(0, 32'h0, 0);

    // randomised traffic
    for (int n = 0; n < 200; n++) begin
      int k;
      logic [31:0] lo;
      k  = $urandom_range(0, 7);
      lo = 32'($urandom_range(0, 3));
      case (k)
        0: txn(1, 32'($urandom_range(0, RAM_WORDS - 1) * 4) | lo, $urandom);
        1, 2: txn(0, 32'($urandom_range(0, RAM_WORDS - 1) * 4) | lo, 0);
        3: txn(1, IO_BASE | lo, $urandom);
        4: txn(0, IO_BASE | lo, 0);
        5: txn(1'($urandom_range(0, 1)), (IO_BASE + 32'h4) | lo, $urandom);
        6: txn(0, (IO_BASE + ($urandom_range(0, 1) ? 32'h8 : 32'hC)) | lo, 0);
        default: txn(1'($urandom_range(0, 1)), unm[$urandom_range(0, 4)] | lo, $urandom);
      endcase
    end

    // timer compare, W1C, and clear colliding with a match
    check("irq_before", timer_irq, 0);
    txn(1, IO_BASE + 32'h8, 32'h0);
    w2 = tc_w;
    txn(1, IO_BASE + 32'hC, 32'd20);
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #1;
      check("irq_match", timer_irq, (edge_no >= w2 + 21) ? 1 : 0);
    end
    flag_m = 1'b1;
    txn(0, IO_BASE + 32'h10, 0);
    txn(0, IO_BASE + 32'h8, 0);
    txn(1, IO_BASE + 32'h10, 32'h1);
    check("irq_cleared", timer_irq, 0);
    txn(0, IO_BASE + 32'h10, 0);
    txn(1, IO_BASE + 32'h8, 32'h0);
    w2 = tc_w;
    while (edge_no < w2 + 20) begin @(posedge clk); #1; end
    txn(1, IO_BASE + 32'h10, 32'h1);   // accepted on the match edge
    flag_m = 1'b1;
    check("irq_set_wins", timer_irq, 1);
    txn(0, IO_BASE + 32'h10, 0);

    // reset while a RAM load is waiting
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h10;
    @(posedge clk); #1;
    req_valid = 1'b0;
    check("wait_no_rsp", rsp_valid, 0);
    do_reset();
    @(posedge clk); #1;
    check("post_rst_rsp", rsp_valid, 0);
    check("post_rst_ready", req_ready, 1);
    check("post_rst_leds", {24'h0, leds}, 0);
    txn(0, 32'h10, 0);                  // RAM survives reset
    txn(0, IO_BASE + 32'hC, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
